// File: rtl/wide_add_sub_seq_pkg.sv
// Shared types and constants for the wide add/subtract sequencer.
package wide_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Slice counter needs at least one bit even when a single slice is used.
  function automatic int unsigned cnt_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/wide_add_sub_seq_if.sv
// Request/result handshake bundle for wide_add_sub_seq.
interface wide_add_sub_seq_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned WORDS = 4
);
  localparam int unsigned W = N * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res;
  logic         res_cout;
  logic         res_ovf;
  logic         busy;

  modport master (
    output in_valid, in_a, in_b, in_sub, res_ready,
    input  in_ready, res_valid, res, res_cout, res_ovf, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, res_ready,
    output in_ready, res_valid, res, res_cout, res_ovf, busy
  );
endinterface

// File: rtl/wide_add_sub_seq_add_slice.sv
// N-bit ripple-carry adder slice; operands are used exactly as presented.
module add_slice #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic c;

  always_comb begin
    sum = '0;
    c   = cin;
    for (int unsigned i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/wide_add_sub_seq.sv
// Wide add/subtract sequenced through one N-bit adder slice, LSB slice first,
// with the inter-slice carry held in a register.
module wide_add_sub_seq
  import wide_add_sub_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned WORDS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  wide_add_sub_seq_if.slave bus
);

  localparam int unsigned W  = N * WORDS;
  localparam int unsigned CW = cnt_width(WORDS);

  state_t state, state_nx;

  logic [W-1:0]  a_q, b_q, res_q;
  logic          sub_q, carry_q, cout_q, ovf_q;
  logic [CW-1:0] cnt_q;

  logic [N-1:0] a_sl, b_sl, sum_sl;
  logic         slice_cout;
  logic         last;
  logic         accept;
  logic         in_ready, res_valid, busy;

  // Subtraction is A + ~B + 1: the +1 comes from seeding carry with in_sub.
  assign a_sl   = a_q[N*int'(cnt_q) +: N];
  assign b_sl   = b_q[N*int'(cnt_q) +: N] ^ {N{sub_q}};
  assign last   = (cnt_q == CW'(WORDS - 1));
  assign accept = bus.in_valid && in_ready;

  add_slice #(.N(N)) u_slice (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry_q),
    .sum  (sum_sl),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_nx = RUN;
      RUN:     if (last)         state_nx = DONE;
      DONE:    if (bus.res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    res_valid = (state == DONE);
    busy      = (state == RUN) || (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= OP_ADD;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.in_a;
      b_q     <= bus.in_b;
      sub_q   <= bus.in_sub;
      carry_q <= bus.in_sub;
      cnt_q   <= '0;
    end else if (state == RUN) begin
      res_q[N*int'(cnt_q) +: N] <= sum_sl;
      carry_q <= slice_cout;
      cnt_q   <= cnt_q + 1'b1;
      if (last) begin
        cout_q <= slice_cout;
        ovf_q  <= (a_sl[N-1] == b_sl[N-1]) && (sum_sl[N-1] != a_sl[N-1]);
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.res_valid = res_valid;
  assign bus.busy      = busy;
  assign bus.res       = res_q;
  assign bus.res_cout  = cout_q;
  assign bus.res_ovf   = ovf_q;

endmodule

// File: tb/tb_wide_add_sub_seq.sv
// Self-checking bench for wide_add_sub_seq (16-bit and single-slice 4-bit instances).
module tb_wide_add_sub_seq;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  wide_add_sub_seq_if #(.N(4), .WORDS(4)) bus ();
  wide_add_sub_seq_if #(.N(4), .WORDS(1)) bus1 ();

  wide_add_sub_seq #(.N(4), .WORDS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  wide_add_sub_seq #(.N(4), .WORDS(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void model(input int w, input longint a, input longint b, input bit sub,
                                output longint r, output bit co, output bit ov);
    longint m, sa, sb, ur, sr;
    m  = longint'(1) << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (sub) begin
      ur = a - b;
      sr = sa - sb;
      co = (a >= b);
    end else begin
      ur = a + b;
      sr = sa + sb;
      co = (ur >= m);
    end
    r  = ((ur % m) + m) % m;
    ov = (sr >= m / 2) || (sr < -(m / 2));
  endfunction

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic sub,
                      input logic [15:0] er, input logic ec, input logic eo, input string nm);
    int lat;
    bus.in_a = a; bus.in_b = b; bus.in_sub = sub; bus.in_valid = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL %s ready_before: got %b expected 1", nm, bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.res_valid !== 1'b1 && lat < 20) begin
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL %s ready_busy: got %b expected 0", nm, bus.in_ready); end
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL %s latency: got %0d expected 4", nm, lat); end
    checks++;
    if (bus.res !== er) begin errors++; $display("FAIL %s res: got %h expected %h", nm, bus.res, er); end
    checks++;
    if (bus.res_cout !== ec) begin errors++; $display("FAIL %s cout: got %b expected %b", nm, bus.res_cout, ec); end
    checks++;
    if (bus.res_ovf !== eo) begin errors++; $display("FAIL %s ovf: got %b expected %b", nm, bus.res_ovf, eo); end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s release: got valid=%b ready=%b busy=%b expected 0 1 0", nm, bus.res_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0; bus.in_sub = 0; bus.res_ready = 0;
    bus1.in_valid = 0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_sub = 0; bus1.res_ready = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.res, bus.res_cout, bus.res_ovf, bus.res_valid, bus.busy, bus.in_ready} !== {16'h0, 5'b00001}) begin
      errors++;
      $display("FAIL reset16: got res=%h c=%b o=%b v=%b b=%b r=%b expected 0000 0 0 0 0 1",
               bus.res, bus.res_cout, bus.res_ovf, bus.res_valid, bus.busy, bus.in_ready);
    end
    checks++;
    if ({bus1.res, bus1.res_valid, bus1.busy, bus1.in_ready} !== {4'h0, 3'b001}) begin
      errors++;
      $display("FAIL reset4: got res=%h v=%b b=%b r=%b expected 0 0 0 1", bus1.res, bus1.res_valid, bus1.busy, bus1.in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    op16(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, "add");
    op16(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
    op16(16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, "sub_noborrow");
    op16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
    op16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "add_carry");
    op16(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    logic sub;
    longint r;
    bit co, ov;
    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      if (i % 6 == 0) b = a;
      model(16, longint'(a), longint'(b), sub, r, co, ov);
      op16(a, b, sub, 16'(r), co, ov, "random");
    end
  endtask

  task automatic test_backpressure();
    int n;
    bus.in_a = 16'h1111; bus.in_b = 16'h2222; bus.in_sub = 1'b0; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL bp_wait: got valid=%b expected 1", bus.res_valid); end
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_a = 16'($urandom); bus.in_b = 16'($urandom); bus.in_sub = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({bus.res_valid, bus.in_ready, bus.res, bus.res_cout, bus.res_ovf} !== {2'b10, 16'h3333, 2'b00}) begin
        errors++;
        $display("FAIL bp_hold: got v=%b r=%b res=%h c=%b o=%b expected 1 0 3333 0 0",
                 bus.res_valid, bus.in_ready, bus.res, bus.res_cout, bus.res_ovf);
      end
    end
    bus.in_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got v=%b r=%b expected 0 1", bus.res_valid, bus.in_ready);
    end
    op16(16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, "bp_next");
  endtask

  task automatic test_reset_mid_run();
    bus.in_a = 16'hABCD; bus.in_b = 16'h1357; bus.in_sub = 1'b1; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrun_busy: got %b expected 1", bus.busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.res, bus.res_cout, bus.res_ovf, bus.res_valid, bus.busy, bus.in_ready} !== {16'h0, 5'b00001}) begin
      errors++;
      $display("FAIL midrun_reset: got res=%h c=%b o=%b v=%b b=%b r=%b expected 0000 0 0 0 0 1",
               bus.res, bus.res_cout, bus.res_ovf, bus.res_valid, bus.busy, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op16(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_words1();
    int lat;
    longint r;
    bit co, ov;
    logic [3:0] q_res[$];
    logic       q_co[$];
    int last_acc, acc_cnt, res_cnt;
    bus1.in_a = 4'h9; bus1.in_b = 4'h3; bus1.in_sub = 1'b1; bus1.in_valid = 1'b1;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    lat = 0;
    while (bus1.res_valid !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL w1_latency: got %0d expected 1", lat); end
    checks++;
    if (bus1.res !== 4'h6 || bus1.res_cout !== 1'b1) begin
      errors++;
      $display("FAIL w1_sub: got res=%h c=%b expected 6 1", bus1.res, bus1.res_cout);
    end
    bus1.res_ready = 1'b1;
    @(negedge clk);
    last_acc = -1; acc_cnt = 0; res_cnt = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      if (bus1.res_valid === 1'b1) begin
        checks++;
        if (q_res.size() == 0) begin
          errors++; $display("FAIL w1_b2b_extra: got unexpected result %h expected none", bus1.res);
        end else begin
          if (bus1.res !== q_res[0] || bus1.res_cout !== q_co[0]) begin
            errors++;
            $display("FAIL w1_b2b_res: got %h/%b expected %h/%b", bus1.res, bus1.res_cout, q_res[0], q_co[0]);
          end
          void'(q_res.pop_front()); void'(q_co.pop_front());
        end
        res_cnt++;
      end
      bus1.in_a = 4'($urandom); bus1.in_b = 4'($urandom); bus1.in_sub = 1'($urandom); bus1.in_valid = 1'b1;
      #1;
      if (bus1.in_ready === 1'b1) begin
        model(4, longint'(bus1.in_a), longint'(bus1.in_b), bus1.in_sub, r, co, ov);
        q_res.push_back(4'(r)); q_co.push_back(co);
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc !== 3) begin errors++; $display("FAIL w1_spacing: got %0d expected 3", cyc - last_acc); end
        end
        last_acc = cyc;
        acc_cnt++;
      end
      @(negedge clk);
    end
    bus1.in_valid = 1'b0;
    checks++;
    if (acc_cnt !== 5) begin errors++; $display("FAIL w1_accepts: got %0d expected 5", acc_cnt); end
    checks++;
    if (res_cnt < 4) begin errors++; $display("FAIL w1_results: got %0d expected >=4", res_cnt); end
    bus1.res_ready = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_words1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
